// File: rtl/nios_system_sysid_pkg.sv
// rtl/nios_system_sysid_pkg.sv - shared types and constants for the sysid checker
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID_REQ,
    ST_RD_ID_WAIT,
    ST_RD_TS_REQ,
    ST_RD_TS_WAIT,
    ST_CHECK,
    ST_RECOVER,
    ST_DONE
  } state_t;

  typedef logic [1:0] fail_code_t;

  localparam fail_code_t FAIL_NONE    = 2'd0;
  localparam fail_code_t FAIL_ID      = 2'd1;
  localparam fail_code_t FAIL_TS      = 2'd2;
  localparam fail_code_t FAIL_TIMEOUT = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // ID mismatch is reported in preference to a timestamp mismatch
  function automatic fail_code_t classify(input logic [31:0] id_word,
                                          input logic [31:0] ts_word,
                                          input logic [31:0] exp_id,
                                          input logic [31:0] exp_ts);
    if (id_word != exp_id) return FAIL_ID;
    if (ts_word != exp_ts) return FAIL_TS;
    return FAIL_NONE;
  endfunction

endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// rtl/nios_system_sysid_checker_if.sv - Avalon-MM read port between checker and sysid slave
interface nios_system_sysid_checker_if;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata,
    input  m_readdatavalid
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata,
    output m_readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_timeout_counter.sv
// rtl/nios_system_sysid_timeout_counter.sv - clearable up-counter with terminal flag
module nios_system_sysid_timeout_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // flags the limit-th enabled cycle after a clear
  assign terminal = enable && (count == limit - WIDTH'(1));

endmodule

// File: rtl/nios_system_sysid_checker.sv
// rtl/nios_system_sysid_checker.sv - boot-time sysid read/compare sequencer (option: SYSID_CHECK_AUTOSTART_EN)
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1476653784,
  parameter int          TIMEOUT_CYCLES     = 1023,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  nios_system_sysid_checker_if.master   bus,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [1:0]                    fail_code,
  output logic [31:0]                   id_value,
  output logic [31:0]                   timestamp_value
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRIES);

  state_t     state;
  logic [3:0] retry_cnt;
  logic       read_q;
  logic       address_q;
  logic       start_int;
  logic       tmo_terminal;
  logic       in_req;
  logic       in_wait;
  logic       in_read;
  logic       data_arrived;
  logic       timed_out;
  logic       enter_req;
  logic       enter_recover;
  logic       cnt_clear;
  logic       cnt_enable;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic boot_seen;
  logic auto_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      boot_seen  <= 1'b0;
      auto_start <= 1'b0;
    end else begin
      boot_seen  <= 1'b1;
      auto_start <= ~boot_seen;
    end
  end

  assign start_int = start | auto_start;
`else
  assign start_int = start;
`endif

  assign in_req       = (state == ST_RD_ID_REQ) || (state == ST_RD_TS_REQ);
  assign in_wait      = (state == ST_RD_ID_WAIT) || (state == ST_RD_TS_WAIT);
  assign in_read      = in_req || in_wait;
  // a response landing on the terminal cycle still counts as in time
  assign data_arrived = in_wait && bus.m_readdatavalid;
  assign timed_out    = in_read && tmo_terminal && !data_arrived;

  assign enter_recover = timed_out && (retry_cnt < RETRY_LIMIT);
  assign enter_req     = (((state == ST_IDLE) || (state == ST_DONE)) && start_int)
                       || ((state == ST_RD_ID_WAIT) && bus.m_readdatavalid)
                       || ((state == ST_RECOVER) && tmo_terminal);
  assign cnt_clear     = enter_req || enter_recover;
  assign cnt_enable    = in_read || (state == ST_RECOVER);

  nios_system_sysid_timeout_counter #(
    .WIDTH (16)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .limit    (TIMEOUT_LIMIT),
    .terminal (tmo_terminal)
  );

  assign bus.m_read    = read_q;
  assign bus.m_address = address_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      read_q          <= 1'b0;
      address_q       <= SYSID_ADDR_ID;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_code       <= FAIL_NONE;
      id_value        <= '0;
      timestamp_value <= '0;
      retry_cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (timed_out) begin
        read_q <= 1'b0;
        if (enter_recover) begin
          state <= ST_RECOVER;
        end else begin
          state     <= ST_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          fail_code <= FAIL_TIMEOUT;
        end
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (start_int) begin
              state     <= ST_RD_ID_REQ;
              read_q    <= 1'b1;
              address_q <= SYSID_ADDR_ID;
              busy      <= 1'b1;
              pass      <= 1'b0;
              fail_code <= FAIL_NONE;
              retry_cnt <= '0;
            end
          end
          ST_RD_ID_REQ: begin
            if (!bus.m_waitrequest) begin
              state  <= ST_RD_ID_WAIT;
              read_q <= 1'b0;
            end
          end
          ST_RD_ID_WAIT: begin
            if (bus.m_readdatavalid) begin
              id_value  <= bus.m_readdata;
              state     <= ST_RD_TS_REQ;
              read_q    <= 1'b1;
              address_q <= SYSID_ADDR_TS;
            end
          end
          ST_RD_TS_REQ: begin
            if (!bus.m_waitrequest) begin
              state  <= ST_RD_TS_WAIT;
              read_q <= 1'b0;
            end
          end
          ST_RD_TS_WAIT: begin
            if (bus.m_readdatavalid) begin
              timestamp_value <= bus.m_readdata;
              state           <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            fail_code <= classify(id_value, timestamp_value, EXPECTED_ID, EXPECTED_TIMESTAMP);
            pass      <= (classify(id_value, timestamp_value, EXPECTED_ID, EXPECTED_TIMESTAMP) == FAIL_NONE);
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
          ST_RECOVER: begin
            // late responses from the abandoned read are drained here
            if (tmo_terminal) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= ST_RD_ID_REQ;
              read_q    <= 1'b1;
              address_q <= SYSID_ADDR_ID;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb/tb_nios_system_sysid_checker.sv - self-checking bench for nios_system_sysid_checker
module tb_nios_system_sysid_checker;
  import nios_system_sysid_pkg::*;

  localparam int          T      = 8;
  localparam int          R      = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1476653784;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value, timestamp_value;

  nios_system_sysid_checker_if bus();

  nios_system_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (T),
    .MAX_RETRIES        (R)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .id_value        (id_value),
    .timestamp_value (timestamp_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave model: per-read wait/latency overrides, otherwise defaults
  typedef struct {int wt; int lat; bit bad;} rd_cfg_t;
  typedef struct {int due; logic [31:0] data;} resp_t;
  rd_cfg_t     cfg_q[$];
  rd_cfg_t     cur;
  resp_t       pend[$];
  resp_t       rsp;
  int          acc_addr[$];
  int          sl_wait = 0, sl_lat = 1, stall = 0, rd_cycles = 0;
  bit          sl_respond = 1'b1, spur = 1'b0, active = 1'b0, stalled = 1'b0;
  logic        stall_addr = 1'b0;
  logic [31:0] sl_id = EXP_ID, sl_ts = EXP_TS;

  always @(negedge clock) begin
    if (!reset_n) begin
      pend.delete();
      active = 1'b0;
      stalled = 1'b0;
      stall = 0;
      bus.m_waitrequest = 1'b0;
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata = 32'd0;
    end else begin
      if (stalled) chk("hold_stable", {bus.m_read, bus.m_address}, {1'b1, stall_addr});
      stalled = 1'b0;
      bus.m_waitrequest = 1'b0;
      if (bus.m_read) begin
        rd_cycles++;
        if (!active) begin
          active = 1'b1;
          stall = 0;
          if (cfg_q.size() > 0) cur = cfg_q.pop_front();
          else cur = '{sl_wait, sl_lat, 1'b0};
        end
        if (stall < cur.wt) begin
          stall++;
          bus.m_waitrequest = 1'b1;
          stalled = 1'b1;
          stall_addr = bus.m_address;
        end else begin
          active = 1'b0;
          acc_addr.push_back(int'(bus.m_address));
          if (sl_respond) begin
            rsp.due  = cyc + cur.lat;
            rsp.data = bus.m_address ? sl_ts : sl_id;
            if (cur.bad) rsp.data = rsp.data ^ 32'hDEAD_BEEF;
            pend.push_back(rsp);
          end
        end
      end
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata = $urandom;
      if (spur) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 32'hBAD0_0001;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
        rsp = pend.pop_front();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = rsp.data;
      end
    end
  end

  // reference: a read costs (wait + 1) request cycles plus latency wait cycles
  function automatic int exp_done_cycle(int w_id, int l_id, int w_ts, int l_ts);
    return 1 + (w_id + 1 + l_id) + (w_ts + 1 + l_ts) + 1;
  endfunction

  function automatic logic [1:0] exp_code(logic [31:0] id, logic [31:0] ts);
    if (id != EXP_ID) return 2'd1;
    if (ts != EXP_TS) return 2'd2;
    return 2'd0;
  endfunction

  int s0;
  int at;

  task automatic start_pulse();
    @(negedge clock);
    start = 1'b1;
    s0 = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        when = cyc - s0;
        break;
      end
    end
    @(negedge clock);
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic check_result(input string tag, input int exp_at, input logic [1:0] code,
                              input logic [31:0] id, input logic [31:0] ts);
    chk({tag, "_done_cycle"}, at, exp_at);
    chk({tag, "_fail_code"}, fail_code, code);
    chk({tag, "_pass"}, pass, code == 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_id_value"}, id_value, id);
    chk({tag, "_ts_value"}, timestamp_value, ts);
  endtask

  initial begin
    int          wi, li, wt, lt;
    logic [31:0] rid, rts;

    // reset state
    repeat (3) @(negedge clock);
    chk("reset_status", {bus.m_read, bus.m_address, busy, done, pass, fail_code}, 7'd0);
    chk("reset_words", {id_value, timestamp_value}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_no_autostart", {busy, bus.m_read}, 2'b00);

    // minimum latency, matching slave
    acc_addr.delete();
    rd_cycles = 0;
    start_pulse();
    wait_done(40, at);
    check_result("min", exp_done_cycle(0, 1, 0, 1), 2'd0, EXP_ID, EXP_TS);
    chk("min_accepts", acc_addr.size(), 2);
    if (acc_addr.size() == 2) chk("min_addr_order", {acc_addr[0][0], acc_addr[1][0]}, 2'b01);
    chk("min_read_cycles", rd_cycles, 2);

    // four waitrequest cycles per read, extra start while busy
    sl_wait = 4;
    rd_cycles = 0;
    start_pulse();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(60, at);
    check_result("wait4", exp_done_cycle(4, 1, 4, 1), 2'd0, EXP_ID, EXP_TS);
    chk("wait4_read_cycles", rd_cycles, 10);
    sl_wait = 0;

    // ID mismatch with wrong timestamp too
    sl_id = 32'd5;
    sl_ts = EXP_TS + 32'd1;
    start_pulse();
    wait_done(40, at);
    check_result("id_bad", exp_done_cycle(0, 1, 0, 1), 2'd1, 32'd5, EXP_TS + 32'd1);

    // start and stray readdatavalid together in DONE
    sl_id = EXP_ID;
    sl_ts = EXP_TS;
    @(posedge clock);
    #1;
    start = 1'b1;
    spur = 1'b1;
    s0 = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
    spur = 1'b0;
    chk("done_start_wins_busy", busy, 1'b1);
    chk("done_capture_ignored", id_value, 32'd5);
    wait_done(40, at);
    check_result("restart", exp_done_cycle(0, 1, 0, 1), 2'd0, EXP_ID, EXP_TS);

    // data on the terminal timeout cycle wins
    cfg_q.push_back('{0, T - 1, 1'b0});
    start_pulse();
    wait_done(60, at);
    check_result("edge_data", exp_done_cycle(0, T - 1, 0, 1), 2'd0, EXP_ID, EXP_TS);

    // fabric never answers: all attempts time out
    sl_respond = 1'b0;
    start_pulse();
    wait_done(200, at);
    check_result("timeout", 1 + (R + 1) * T + R * T, 2'd3, EXP_ID, EXP_TS);
    repeat (2) @(negedge clock);
    chk("timeout_idle_after", {busy, bus.m_read, fail_code}, 4'b0011);
    sl_respond = 1'b1;

    // late bad word lands in RECOVER, retry succeeds
    cfg_q.push_back('{0, T + 2, 1'b1});
    start_pulse();
    wait_done(120, at);
    check_result("stale", 2 * T + exp_done_cycle(0, 1, 0, 1), 2'd0, EXP_ID, EXP_TS);

    // randomized stall/latency/data against the model
    for (int k = 0; k < 6; k++) begin
      wi = $urandom_range(0, 3);
      li = $urandom_range(1, 3);
      wt = $urandom_range(0, 3);
      lt = $urandom_range(1, 3);
      rid = $urandom_range(0, 1) ? EXP_ID : $urandom;
      rts = $urandom_range(0, 1) ? EXP_TS : $urandom;
      sl_id = rid;
      sl_ts = rts;
      cfg_q.push_back('{wi, li, 1'b0});
      cfg_q.push_back('{wt, lt, 1'b0});
      start_pulse();
      wait_done(60, at);
      check_result($sformatf("rand%0d", k), exp_done_cycle(wi, li, wt, lt), exp_code(rid, rts), rid, rts);
    end

    // reset asserted while waiting for the timestamp word
    sl_id = 32'h1234;
    sl_ts = EXP_TS;
    cfg_q.push_back('{0, 1, 1'b0});
    cfg_q.push_back('{0, 4, 1'b0});
    acc_addr.delete();
    start_pulse();
    for (int i = 0; i < 20 && acc_addr.size() < 2; i++) @(negedge clock);
    chk("rst_reached_ts", acc_addr.size(), 2);
    @(negedge clock);
    chk("rst_in_ts_wait", {busy, bus.m_read}, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_status", {bus.m_read, bus.m_address, busy, done, pass, fail_code}, 7'd0);
    chk("rst_async_words", {id_value, timestamp_value}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_release_idle", {busy, bus.m_read, done}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_checker.md
# nios_system_sysid_checker

Boot-time sequencer that masters the system-ID Avalon slave. On a start request it reads the ID word (address 0) and timestamp word (address 1), compares both against build-time expected values, and reports pass/fail. It sits between the reset controller and the Nios II bring-up logic, gating software release on a matching hardware image, with timeout and bounded retry on a stalled fabric.

## Interface
- EXPECTED_ID, 32'd0, required value at sysid address 0
- EXPECTED_TIMESTAMP, 32'd1476653784, required value at sysid address 1
- TIMEOUT_CYCLES, 1023, max cycles per read (request + wait); range 1..65535
- MAX_RETRIES, 3, sequence restarts allowed after a timeout; range 0..15

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  sequence request, sampled only in IDLE or DONE
- m_address  out  1  sysid word select
- m_read  out  1  Avalon read strobe
- m_waitrequest  in  1  fabric stall
- m_readdata  in  32  read data
- m_readdatavalid  in  1  read data qualifier
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last sequence matched, held until next start
- fail_code  out  2  0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
- id_value  out  32  last captured ID word
- timestamp_value  out  32  last captured timestamp word

## Operation
- States: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, CHECK, RECOVER, DONE.
- IDLE/DONE + start -> RD_ID_REQ; clears pass, fail_code, retry count.
- *_REQ: m_read=1, m_address=0 (ID) or 1 (TS); held stable while m_waitrequest=1; accept when m_waitrequest=0 -> matching *_WAIT.
- *_WAIT: m_read=0; m_readdatavalid=1 captures m_readdata into id_value/timestamp_value -> RD_TS_REQ / CHECK.
- m_readdatavalid outside *_WAIT is ignored (fabric latency >= 1).
- Timeout counter (16-bit) clears on entering each *_REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> RECOVER if retries < MAX_RETRIES, else DONE with fail_code=3.
- RECOVER: m_read=0, discards m_readdatavalid for TIMEOUT_CYCLES cycles, increments retry count, -> RD_ID_REQ.
- CHECK: ID mismatch -> fail_code=1 (priority over timestamp); else TS mismatch -> 2; else pass=1. -> DONE. No retry on mismatch.
- busy=1 in every state except IDLE and DONE; start while busy ignored.

## Timing
- Reset values: m_read 0, m_address 0, busy 0, done 0, pass 0, fail_code 0, id_value 0, timestamp_value 0; state IDLE.
- All outputs registered; m_read/m_address change only at clock edges.
- Minimum latency (waitrequest low, readdatavalid 1 cycle after accept): start high in cycle 0 -> m_read cycles 1 and 3 -> done high in cycle 6.
- done high exactly one cycle on DONE entry; pass/fail_code valid from that cycle.
- start and m_readdatavalid same cycle in DONE: start wins, capture ignored.
- Timeout and m_readdatavalid in same cycle: data wins, counter ignored.
- Reset mid-sequence: asynchronous return to reset values; m_read drops immediately; no pending response tracked.

## Configuration
- SYSID_CHECK_AUTOSTART_EN defined: one internal start pulse generated on the first clock after reset_n deasserts; external start still honoured later.
- Not defined: sequence runs only on external start.

## Structure
- Package nios_system_sysid_pkg: state enum, fail-code constants (FAIL_NONE/ID/TS/TIMEOUT), address constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1.
- Sub-module nios_system_sysid_timeout_counter: clear/enable/terminal-count counter, shared by REQ/WAIT timeout and RECOVER drain.

## Test plan
- Matching slave (ID 0, TS 1476653784), zero-wait, latency 1: start -> done in cycle 6, pass=1, fail_code=0, two m_read pulses at addresses 0 then 1.
- Slave returns ID 5, TS wrong: done with pass=0, fail_code=1, id_value=5.
- m_waitrequest held 4 cycles on each read: m_read/m_address stable throughout, done in cycle 14, pass=1.
- TIMEOUT_CYCLES=8, MAX_RETRIES=2, no readdatavalid ever: three attempts separated by 8-cycle RECOVER, done with fail_code=3, busy low after.
- Late readdatavalid during RECOVER with bad data, retry succeeds: stale word discarded, pass=1.
- Reset asserted in RD_TS_WAIT: all outputs zero same cycle; with SYSID_CHECK_AUTOSTART_EN, m_read reasserts at address 0 two cycles after reset release.
